// File: rtl/uart_rx_os.sv
// Oversampled UART receiver: mid-bit sampling on an external baud tick, single-entry
// valid/ready holding register. Define UART_RX_MAJORITY_VOTE_EN for 2-of-3 bit voting.
module uart_rx_os #(
  parameter int DATA_WIDTH  = 8,
  parameter int OVERSAMPLE  = 16,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  baud_tick,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  rx_parity_err,
  output logic                  rx_frame_err,
  output logic                  rx_break,
  output logic                  rx_overrun,
  output logic                  rx_busy
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam int BC_W = $clog2(DATA_WIDTH);
  localparam logic [OS_W-1:0] OS_MAX    = OS_W'(OVERSAMPLE - 1);
  localparam logic [BC_W-1:0] LAST_BIT  = BC_W'(DATA_WIDTH - 1);
  localparam logic            LAST_STOP = 1'(STOP_BITS - 1);

  // With voting the decision lands one tick after the centre, so the bit counter
  // restarts at 1 to keep the following bit centres where they would otherwise be.
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam logic [OS_W-1:0] START_DEC  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] BIT_DEC    = '0;
  localparam logic [OS_W-1:0] OS_RESTART = OS_W'(1);
`else
  localparam logic [OS_W-1:0] START_DEC  = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] BIT_DEC    = OS_MAX;
  localparam logic [OS_W-1:0] OS_RESTART = '0;
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t                state_q, state_d;
  logic [OS_W-1:0]       os_cnt_q, os_cnt_d, os_inc;
  logic [BC_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic                  stop_cnt_q, stop_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_bit_q, par_bit_d, par_err_q, par_err_d;
  logic                  frm_err_q, frm_err_d, stop_hi_q, stop_hi_d;
  logic                  meta_q, rx_s_q;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d, pe_q, pe_d, fe_q, fe_d, brk_q, brk_d;
  logic                  ovr_q, ovr_d;
  logic                  bit_val, dec_tick, frame_done, fin_fe, fin_brk;

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist_q <= 2'b11;
    end else if (baud_tick) begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign bit_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign bit_val = rx_s_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= 1'b1;
      rx_s_q     <= 1'b1;
      state_q    <= S_IDLE;
      os_cnt_q   <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      shift_q    <= '0;
      par_bit_q  <= 1'b0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      stop_hi_q  <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
      brk_q      <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      meta_q     <= rx;
      rx_s_q     <= meta_q;
      state_q    <= state_d;
      os_cnt_q   <= os_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      shift_q    <= shift_d;
      par_bit_q  <= par_bit_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      stop_hi_q  <= stop_hi_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      pe_q       <= pe_d;
      fe_q       <= fe_d;
      brk_q      <= brk_d;
      ovr_q      <= ovr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    os_cnt_d   = os_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    shift_d    = shift_q;
    par_bit_d  = par_bit_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    stop_hi_d  = stop_hi_q;
    data_d     = data_q;
    valid_d    = valid_q;
    pe_d       = pe_q;
    fe_d       = fe_q;
    brk_d      = brk_q;
    ovr_d      = 1'b0;
    os_inc     = (os_cnt_q == OS_MAX) ? '0 : os_cnt_q + 1'b1;

    case (state_q)
      S_IDLE: begin
        if (baud_tick && !rx_s_q) begin
          state_d    = S_START;
          os_cnt_d   = '0;
          bit_cnt_d  = '0;
          stop_cnt_d = 1'b0;
          par_bit_d  = 1'b0;
          par_err_d  = 1'b0;
          frm_err_d  = 1'b0;
          stop_hi_d  = 1'b0;
        end
      end
      S_START: begin
        if (dec_tick) begin
          state_d  = bit_val ? S_IDLE : S_DATA;
          os_cnt_d = bit_val ? '0 : OS_RESTART;
        end else if (baud_tick) begin
          os_cnt_d = os_cnt_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_tick) os_cnt_d = os_inc;
        if (dec_tick) begin
          shift_d = {bit_val, shift_q[DATA_WIDTH-1:1]};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (baud_tick) os_cnt_d = os_inc;
        if (dec_tick) begin
          par_bit_d = bit_val;
          if (PARITY_MODE == 1) par_err_d = ~(^shift_q ^ bit_val);
          else                  par_err_d = ^shift_q ^ bit_val;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (baud_tick) os_cnt_d = os_inc;
        if (dec_tick) begin
          frm_err_d = frm_err_q | ~bit_val;
          stop_hi_d = stop_hi_q | bit_val;
          if (stop_cnt_q == LAST_STOP) begin
            state_d  = S_IDLE;
            os_cnt_d = '0;
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A pop in the completion cycle frees the slot for the new frame.
    if (frame_done) begin
      if (!valid_q || rx_ready) begin
        valid_d = 1'b1;
        data_d  = shift_q;
        pe_d    = par_err_q;
        fe_d    = fin_fe;
        brk_d   = fin_brk;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
    rx_busy       = (state_q != S_IDLE);
    dec_tick      = baud_tick && (os_cnt_q == ((state_q == S_START) ? START_DEC : BIT_DEC));
    frame_done    = dec_tick && (state_q == S_STOP) && (stop_cnt_q == LAST_STOP);
    fin_fe        = frm_err_q | ~bit_val;
    fin_brk       = (shift_q == '0) && ((PARITY_MODE == 0) || !par_bit_q) && !stop_hi_q && !bit_val;
    rx_data       = data_q;
    rx_valid      = valid_q;
    rx_parity_err = pe_q;
    rx_frame_err  = fe_q;
    rx_break      = brk_q;
    rx_overrun    = ovr_q;
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os: an 8N1 and an 8E2 instance, frame-level reference model,
// expected frames queued at send time and checked by an independent monitor.
module tb_uart_rx_os;
  localparam int OS  = 16;
  localparam int PM0 = 0;
  localparam int SB0 = 1;
  localparam int PM1 = 2;
  localparam int SB1 = 2;
`ifdef UART_RX_MAJORITY_VOTE_EN
  localparam int VOTE = 1;
`else
  localparam int VOTE = 0;
`endif
  localparam int CJ = OS / 2 + 2 + VOTE;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       brk;
  } exp_t;

  logic clk = 1'b0, rst = 1'b1, baud_tick = 1'b1;
  logic rx0 = 1'b1, rx1 = 1'b1, rdy0 = 1'b0, rdy1 = 1'b1;
  logic [7:0] d0, d1;
  logic v0, v1, pe0, pe1, fe0, fe1, brk0, brk1, ovr0, ovr1, busy0, busy1;

  exp_t q0[$];
  exp_t q1[$];
  int n_vec = 0, n_err = 0;
  int ovr_seen[2] = '{0, 0};
  int ovr_exp[2]  = '{0, 0};
  int div = 1, div_cnt = 0;

  uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_MODE(PM0), .STOP_BITS(SB0)) u_n (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx0),
    .rx_data(d0), .rx_valid(v0), .rx_ready(rdy0),
    .rx_parity_err(pe0), .rx_frame_err(fe0), .rx_break(brk0),
    .rx_overrun(ovr0), .rx_busy(busy0)
  );

  uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(OS), .PARITY_MODE(PM1), .STOP_BITS(SB1)) u_e (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx1),
    .rx_data(d1), .rx_valid(v1), .rx_ready(rdy1),
    .rx_parity_err(pe1), .rx_frame_err(fe1), .rx_break(brk1),
    .rx_overrun(ovr1), .rx_busy(busy1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
    end
  endtask

  task automatic pop_check(input int k, input logic [7:0] d, input logic pe,
                           input logic fe, input logic brk);
    exp_t e;
    if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
      n_vec++;
      n_err++;
      $display("FAIL unexpected_frame dut%0d: got data %02h, expected no frame", k, d);
      return;
    end
    e = (k == 0) ? q0.pop_front() : q1.pop_front();
    $display("dut%0d recv data=%02h pe=%0d fe=%0d brk=%0d", k, d, pe, fe, brk);
    chk($sformatf("data_dut%0d", k), d, e.d);
    chk($sformatf("parity_err_dut%0d", k), pe, e.pe);
    chk($sformatf("frame_err_dut%0d", k), fe, e.fe);
    chk($sformatf("break_dut%0d", k), brk, e.brk);
  endtask

  // Monitor: samples just after the driver's negedge updates, i.e. what the next posedge sees.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        if (v0 && rdy0) pop_check(0, d0, pe0, fe0, brk0);
        if (v1 && rdy1) pop_check(1, d1, pe1, fe1, brk1);
        if (ovr0) ovr_seen[0]++;
        if (ovr1) ovr_seen[1]++;
      end
    end
  end

  task automatic tick_wait();
    do begin
      @(negedge clk);
      baud_tick = (div_cnt == 0);
      div_cnt = (div_cnt + 1 >= div) ? 0 : div_cnt + 1;
    end while (!baud_tick);
  endtask

  task automatic set_rx(input int k, input logic v);
    if (k == 0) rx0 = v;
    else        rx1 = v;
  endtask

  task automatic idle(input int k, input int n);
    repeat (n) begin
      tick_wait();
      set_rx(k, 1'b1);
    end
  endtask

  task automatic send_frame(input int k, input logic [7:0] d, input logic p,
                            input logic [1:0] stops, input bit rdy_end, input bit chk_lat);
    logic bits[$];
    exp_t e;
    int pm, sb;
    logic rdy_now;
    bit full, last;
    pm = (k == 0) ? PM0 : PM1;
    sb = (k == 0) ? SB0 : SB1;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(d[i]);
    if (pm != 0) bits.push_back(p);
    for (int s = 0; s < sb; s++) bits.push_back(stops[s]);
    e.d   = d;
    e.pe  = (pm == 1) ? ~(^d ^ p) : (pm == 2) ? (^d ^ p) : 1'b0;
    e.fe  = (sb == 1) ? ~stops[0] : ~(stops[0] & stops[1]);
    e.brk = (d == 8'h00) && (pm == 0 || p == 1'b0) &&
            ((sb == 1) ? ~stops[0] : ~(stops[0] | stops[1]));
    $display("dut%0d send data=%02h par=%0d stops=%02b", k, d, p, stops);
    for (int b = 0; b < bits.size(); b++) begin
      last = (b == bits.size() - 1);
      for (int j = 0; j < OS; j++) begin
        tick_wait();
        if (j == 0) set_rx(k, bits[b]);
        if (last && j == 0) begin
          full    = (k == 0) ? (q0.size() != 0) : (q1.size() != 0);
          rdy_now = (k == 0) ? rdy0 : rdy1;
          if (full && !rdy_end && !rdy_now) ovr_exp[k]++;
          else if (k == 0) q0.push_back(e);
          else q1.push_back(e);
        end
        if (last && rdy_end && j == OS / 2 + 2) begin
          if (k == 0) rdy0 = 1'b1;
          else        rdy1 = 1'b1;
        end
        if (last && chk_lat && j == CJ) chk("latency_before_done", v0, 0);
        if (last && chk_lat && j == CJ + 1) begin
          chk("latency_valid", v0, 1);
          chk("latency_data", d0, d);
        end
      end
    end
  endtask

  initial begin
    int base;
    logic [7:0] rd;
    logic [1:0] st;
    repeat (5) @(negedge clk);
    chk("rst_valid0", v0, 0);
    chk("rst_data0", d0, 0);
    chk("rst_flags0", {pe0, fe0, brk0, ovr0, busy0}, 0);
    chk("rst_valid1", v1, 0);
    chk("rst_data1", d1, 0);
    chk("rst_flags1", {pe1, fe1, brk1, ovr1, busy1}, 0);
    rst = 1'b0;
    idle(0, 20);

    // 8N1 0xA5, latency and hold/pop behaviour
    rdy0 = 1'b0;
    send_frame(0, 8'hA5, 1'b0, 2'b11, 1'b0, 1'b1);
    idle(0, 4);
    chk("hold_kept", v0, 1);
    rdy0 = 1'b1;
    idle(0, 4);
    chk("pop_clears", v0, 0);

    // Even parity on 0x07
    send_frame(1, 8'h07, 1'b0, 2'b11, 1'b0, 1'b0);
    idle(1, 4);
    send_frame(1, 8'h07, 1'b1, 2'b11, 1'b0, 1'b0);
    idle(1, 4);

    // Framing error and break
    send_frame(0, 8'h3C, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(0, OS + 4);
    send_frame(0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(0, OS + 4);
    send_frame(1, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
    idle(1, OS + 4);
    send_frame(1, 8'h00, 1'b0, 2'b10, 1'b0, 1'b0);
    idle(1, 4);
    send_frame(1, 8'h00, 1'b1, 2'b00, 1'b0, 1'b0);
    idle(1, OS + 4);

    // Start glitch
    tick_wait();
    rx0 = 1'b0;
    repeat (3) tick_wait();
    tick_wait();
    rx0 = 1'b1;
    chk("glitch_busy", busy0, 1);
    idle(0, OS);
    chk("glitch_idle", busy0, 0);
    chk("glitch_no_valid", v0, 0);

    // Overrun, then simultaneous pop and load
    rdy0 = 1'b0;
    base = ovr_seen[0];
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 2'b11, 1'b0, 1'b0);
    idle(0, 4);
    chk("overrun_pulse", ovr_seen[0] - base, 1);
    chk("overrun_keeps_data", d0, 8'h11);
    rdy0 = 1'b1;
    idle(0, 4);
    rdy0 = 1'b0;
    base = ovr_seen[0];
    send_frame(0, 8'h11, 1'b0, 2'b11, 1'b0, 1'b0);
    send_frame(0, 8'h22, 1'b0, 2'b11, 1'b1, 1'b0);
    idle(0, 4);
    chk("pop_load_no_overrun", ovr_seen[0] - base, 0);

    // Reset mid-frame with a full holding register
    rdy0 = 1'b0;
    send_frame(0, 8'h33, 1'b0, 2'b11, 1'b0, 1'b0);
    idle(0, 2);
    rd = 8'h5A;
    tick_wait();
    rx0 = 1'b0;
    repeat (OS - 1) tick_wait();
    for (int i = 0; i < 4; i++) begin
      tick_wait();
      rx0 = rd[i];
      repeat (OS - 1) tick_wait();
    end
    rst = 1'b1;
    rx0 = 1'b1;
    q0.delete();
    repeat (3) tick_wait();
    rst = 1'b0;
    idle(0, 2 * OS);
    chk("rst_clears_hold", v0, 0);
    chk("rst_idle", busy0, 0);
    rdy0 = 1'b1;
    send_frame(0, 8'h3C, 1'b0, 2'b11, 1'b0, 1'b0);
    idle(0, 4);

    // Random frames, first with a tick every clock, then every other clock
    for (int r = 0; r < 2; r++) begin
      div = r + 1;
      div_cnt = 0;
      for (int i = 0; i < 12; i++) begin
        for (int k = 0; k < 2; k++) begin
          rd = 8'($urandom);
          st = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
          send_frame(k, rd, 1'($urandom), st, 1'b0, 1'b0);
          idle(k, (st != 2'b11) ? OS + $urandom_range(0, 8) : $urandom_range(0, 8));
        end
      end
    end

    div = 1;
    div_cnt = 0;
    for (int w = 0; w < 200 && (q0.size() != 0 || q1.size() != 0); w++) tick_wait();
    chk("drain_dut0", q0.size(), 0);
    chk("drain_dut1", q1.size(), 0);
    chk("overrun_total_dut0", ovr_seen[0], ovr_exp[0]);
    chk("overrun_total_dut1", ovr_seen[1], ovr_exp[1]);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Parametrised, oversampled UART receiver. Successor to the one-sample-per-bit receiver.
- Resolves bits by mid-bit sampling driven by an external baud tick.
- Configurable data width, parity mode and stop-bit count.
- Reports parity, framing, break and overrun conditions.
- Delivers each frame through a single-entry valid/ready holding register to the APB-side register block.

Parameters:
- DATA_WIDTH, 8, data bits per frame; legal 5..9.
- OVERSAMPLE, 16, baud ticks per bit; even, legal 8..32.
- PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, stop bits checked per frame; legal 1..2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- baud_tick  in  1  one-cycle strobe at OVERSAMPLE x baud rate.
- rx  in  1  asynchronous serial line, idle high.
- rx_data  out  DATA_WIDTH  received data, valid while rx_valid.
- rx_valid  out  1  holding register full.
- rx_ready  in  1  consumer accepts rx_data when rx_valid && rx_ready.
- rx_parity_err  out  1  parity mismatch for the held frame.
- rx_frame_err  out  1  any stop bit sampled low for the held frame.
- rx_break  out  1  data all zero and parity (if any) and all stop bits low, for the held frame.
- rx_overrun  out  1  one-cycle pulse: a frame completed while the holding register was full.
- rx_busy  out  1  FSM not in IDLE.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset:
  - FSM returns to IDLE and all counters clear.
  - Sync flops are set to 1.
  - rx_data = 0; all flags and rx_valid = 0; rx_overrun = 0.
  - Reset mid-frame discards the partial frame and clears the holding register.
- Input sync: rx passes through a 2-flop synchroniser (rx_s). All sampling uses rx_s.
- Counters: os_cnt [$clog2(OVERSAMPLE)-1:0]; bit_cnt counts data bits; stop_cnt counts stop bits. Counters advance only on baud_tick.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: on a tick with rx_s == 0, go to START with os_cnt = 0.
  - START: on a tick with os_cnt == OVERSAMPLE/2-1, sample rx_s.
    - rx_s == 1: glitch; return to IDLE silently, no flag.
    - rx_s == 0: os_cnt = 0, go to DATA. Each later sample is therefore at bit centre.
  - DATA: on a tick with os_cnt == OVERSAMPLE-1, sample and shift in LSB first; bit_cnt++.
    - After DATA_WIDTH samples, go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: sample the parity bit p.
    - Odd mode: error when (^data ^ p) == 0.
    - Even mode: error when (^data ^ p) == 1.
    - Go to STOP.
  - STOP: sample each stop bit. Any low sample sets a frame-local frame error.
    - After STOP_BITS samples, complete the frame and go directly to IDLE at mid-stop, so a start edge immediately following is caught.
- Frame completion is the cycle of the final stop-bit sample tick:
  - Holding empty, or rx_valid && rx_ready in that same cycle: load data and flags; rx_valid = 1 next cycle. Latency is 1 clk after the last stop sample tick.
  - Holding full and not popped: drop the new frame, keep old data and flags, pulse rx_overrun for 1 cycle.
- Pop: rx_valid && rx_ready with no simultaneous completion clears rx_valid next cycle.
  - Held data and flags remain stable while rx_valid = 1.
- baud_tick low: FSM and counters hold; sync flops still clock.
- Values 0..255 of 8-bit data pass unmodified. DATA_WIDTH = 9 uses a full 9-bit shift register.

Optional Feature:
- Macro: UART_RX_MAJORITY_VOTE_EN.
- Defined:
  - Each bit value is the 2-of-3 majority of samples at os_cnt = centre-1, centre and centre+1.
    - START centre is OVERSAMPLE/2-1; data/parity/stop centre is OVERSAMPLE-1.
  - The decision is taken on the centre+1 tick.
  - Start-bit validation uses the same majority.
  - Adds 1 tick of decision latency per bit. Bit timing otherwise unchanged.
- Undefined: single centre sample as above. No vote logic is synthesised.

Test Plan:
- 8N1, OVERSAMPLE=16, baud_tick=1, send 0xA5 -> rx_data=0xA5, rx_valid=1 one clk after the stop-bit centre tick, all error flags 0; pop clears rx_valid.
- PARITY_MODE=2, send 0x07 with parity bit 0 -> rx_data=0x07, rx_parity_err=1. Resend with parity bit 1 -> rx_parity_err=0.
- Stop bit driven low with data 0x3C -> rx_frame_err=1, rx_break=0. All-zero frame with low stop -> rx_frame_err=1, rx_break=1, rx_data=0x00.
- rx low for 4 ticks, then high -> no rx_valid, rx_busy returns 0 after the START centre sample, no flags.
- Frames 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, a single rx_overrun pulse at the 0x22 completion. Repeat with rx_ready=1 at the 0x22 completion cycle -> 0x22 loaded, no overrun.
- rst asserted mid-DATA of 0x5A -> rx_valid stays 0. Next frame 0x3C received correctly with no flags.
